nibble_serial_adder_ctrl: RTL and testbench
===========================================

Name: nibble_serial_adder_ctrl

Overview:
Multi-cycle sequencer that adds or subtracts two wide operands by reusing a single 4-bit ripple_adder4 instance, one nibble per clock, least-significant nibble first. It holds the carry between nibbles and drives a start/busy/done handshake. It produces the full-width sum, carry-out and signed overflow. It sits wherever the design needs wide arithmetic but can only spend one 4-bit adder.

Parameters:
NIBBLES, 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES; legal range 1..16.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
start  input  1  request a new operation; sampled only in IDLE or DONE
sub  input  1  0 = A+B, 1 = A-B; latched with start
A  input  W  operand A; latched with start
B  input  W  operand B; latched with start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when S/Cout/V are valid
S  output  W  result (registered)
Cout  output  1  carry out of the MSB nibble (for sub: 1 = no borrow)
V  output  1  two's-complement overflow

Behaviour:
- Reset (async, reset_n=0): state=IDLE; busy=0, done=0, S=0, Cout=0, V=0; internal operand regs, carry reg and nibble index cleared. Reset mid-RUN aborts the operation immediately; no done pulse follows.
- States: IDLE, RUN, DONE. Outputs are registered and decoded from state; busy=(state==RUN), done=(state==DONE).
- IDLE: if start=1 at an edge, latch A and B. Latch B_eff = sub ? ~B : B. Set carry reg = sub, index=0, S=0, go to RUN. Otherwise stay.
- RUN: exactly one ripple_adder4 instance, combinationally fed with A_lat[4i+3:4i], B_eff[4i+3:4i] and the carry reg, where i = index. Each edge writes the adder sum into S[4i+3:4i], loads the adder Cout into the carry reg, and increments the index. On the edge where index==NIBBLES-1: load the Cout output from the adder Cout, compute V, go to DONE.
- V = (A_lat[W-1] == B_eff[W-1]) && (S_new[W-1] != A_lat[W-1]), evaluated on the final RUN edge.
- DONE: lasts one cycle. If start=1 at that edge, the new operation is accepted exactly as from IDLE (back-to-back). Otherwise go to IDLE.
- Latency: start sampled at edge 0. done is high in the cycle after edge NIBBLES, so done is sampled high at edge NIBBLES+1. Throughput is one operation per NIBBLES+1 cycles.
- start while in RUN is ignored; no queuing. A/B/sub changes after acceptance have no effect.
- S, Cout and V hold their values after DONE until the next accepted start. On acceptance S clears to 0. Cout and V hold until the final RUN edge of the new operation. While busy, S shows a partial result: nibbles below the index are valid, the rest are 0.
- NIBBLES=1: a single RUN cycle, then DONE.
- The index register is sized ceil(log2(NIBBLES)) bits with a minimum of 1. It never exceeds NIBBLES-1.

Test Plan:
1. NIBBLES=4, sub=0, A=0x1234, B=0x4321, start pulse at edge 0. Required: busy=1 over edges 1-4, done sampled high only at edge 5, S=0x5555, Cout=0, V=0.
2. A=0xFFFF, B=0x0001, add, which ripples the carry through every nibble. Required: S=0x0000, Cout=1, V=0. A=0x7FFF, B=0x0001, add. Required: S=0x8000, Cout=0, V=1.
3. sub=1, A=0x0005, B=0x0007. Required: S=0xFFFE, Cout=0, V=0. sub=1, A=0x8000, B=0x0001. Required: S=0x7FFF, Cout=1, V=1.
4. Accept 0x1111+0x2222. Hold start=1 with A=0xFFFF during RUN. Required: result S=0x3333, no extra acceptance. Then assert start in the DONE cycle with 0x0001+0x0001. Required: the new op starts immediately and gives S=0x0002 with done 5 cycles later.
5. Drive reset_n=0 asynchronously mid-RUN, after 2 nibbles. Required: busy/done/S/Cout/V are 0 immediately, without waiting for a clock edge. After release, state is IDLE and a fresh 0x00FF+0x0001 gives S=0x0100.
6. NIBBLES=1, A=0xF, B=0x1, add. Required: done sampled at edge 2, S=0x0, Cout=1, V=0.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide add/subtract built on one 4-bit ripple adder, one nibble per clock
// starting with the least-significant nibble, behind a start/busy/done handshake.
`timescale 1ns/1ps

module ripple_adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < 4; i++) begin : g_full_adder
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[4];

endmodule

module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   sub,
  input  logic [4*NIBBLES-1:0]   A,
  input  logic [4*NIBBLES-1:0]   B,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   S,
  output logic                   Cout,
  output logic                   V
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [W-1:0]     a_q;
  logic [W-1:0]     b_eff_q;
  logic [W-1:0]     s_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;
  logic             cout_q;
  logic             v_q;
  logic             busy_q;
  logic             done_q;

  logic             accept;
  logic             last_nibble;
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [3:0]       sum_nib;
  logic             nib_cout;
  logic [W-1:0]     s_new;
  logic             v_new;

  // A new operation may only be taken when no nibble walk is in progress.
  assign accept      = start && ((state_q == IDLE) || (state_q == DONE));
  assign last_nibble = (state_q == RUN) && (idx_q == LAST_IDX);

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_nib = a_q[4*i +: 4];
        b_nib = b_eff_q[4*i +: 4];
      end
    end
  end

  ripple_adder4 u_adder (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_q),
    .sum  (sum_nib),
    .cout (nib_cout)
  );

  // Merge the freshly computed nibble into the running result; on the final
  // nibble this is the complete sum, which the overflow test needs.
  always_comb begin
    s_new = s_q;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        s_new[4*i +: 4] = sum_nib;
      end
    end
  end

  assign v_new = (a_q[W-1] == b_eff_q[W-1]) && (s_new[W-1] != a_q[W-1]);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end

  // Subtraction is A + ~B + 1: the inverted operand is latched and the
  // "+1" enters as the initial carry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q     <= '0;
      b_eff_q <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
    end else if (accept) begin
      a_q     <= A;
      b_eff_q <= sub ? ~B : B;
      carry_q <= sub;
      idx_q   <= '0;
      s_q     <= '0;
    end else if (state_q == RUN) begin
      s_q     <= s_new;
      carry_q <= nib_cout;
      if (last_nibble) begin
        idx_q  <= '0;
        cout_q <= nib_cout;
        v_q    <= v_new;
      end else begin
        idx_q  <= idx_q + 1'b1;
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign S    = s_q;
  assign Cout = cout_q;
  assign V    = v_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Randomized and directed bench for nibble_serial_adder_ctrl, using a 4-nibble
// and a 1-nibble instance checked against a plain-arithmetic reference model.
`timescale 1ns/1ps

module tb_nibble_serial_adder_ctrl;

  localparam int N = 4;
  localparam int W = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy, done, cout, v;
  logic [15:0] s;

  logic        start1 = 1'b0;
  logic        sub1 = 1'b0;
  logic [3:0]  a1 = '0;
  logic [3:0]  b1 = '0;
  logic        busy1, done1, cout1, v1;
  logic [3:0]  s1;

  int errors = 0;
  int checks = 0;

  logic [15:0] prev_s = '0;
  logic        prev_c = 1'b0;
  logic        prev_v = 1'b0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.NIBBLES(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .start(start), .sub(sub), .A(a), .B(b),
    .busy(busy), .done(done), .S(s), .Cout(cout), .V(v)
  );

  nibble_serial_adder_ctrl #(.NIBBLES(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .sub(sub1), .A(a1), .B(b1),
    .busy(busy1), .done(done1), .S(s1), .Cout(cout1), .V(v1)
  );

  // Returns {V, Cout, S} for a w-bit add or subtract using whole-number arithmetic.
  function automatic logic [17:0] model(input int w, input logic [15:0] op_a,
                                        input logic [15:0] op_b, input logic op_sub);
    longint span, half, ua, ub, full, sa, sb, exact;
    logic [17:0] res;
    span  = longint'(1) << w;
    half  = span >> 1;
    ua    = longint'(op_a) % span;
    ub    = longint'(op_b) % span;
    full  = op_sub ? (ua + (span - 1 - ub) + 1) : (ua + ub);
    sa    = (ua >= half) ? ua - span : ua;
    sb    = (ub >= half) ? ub - span : ub;
    exact = op_sub ? (sa - sb) : (sa + sb);
    res[15:0] = 16'(full % span);
    res[16]   = (full >= span);
    res[17]   = (exact < -half) || (exact >= half);
    return res;
  endfunction

  // Starts at a negedge, returns at the negedge of the done cycle.
  task automatic run_op4(input logic [15:0] op_a, input logic [15:0] op_b,
                         input logic op_sub, input bit hold_start);
    logic [17:0] exp;
    logic [15:0] keep;
    logic        exp_c, exp_v;
    exp   = model(W, op_a, op_b, op_sub);
    start = 1'b1;
    a     = op_a;
    b     = op_b;
    sub   = op_sub;
    for (int k = 0; k <= N; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start = hold_start;
        a     = hold_start ? 16'hFFFF : 16'($urandom);
        b     = 16'($urandom);
        sub   = 1'($urandom);
      end
      if (k == N) start = 1'b0;
      keep  = (k >= N) ? 16'hFFFF : 16'((32'd1 << (4 * k)) - 32'd1);
      exp_c = (k == N) ? exp[16] : prev_c;
      exp_v = (k == N) ? exp[17] : prev_v;
      checks++;
      if (busy !== (k < N))
        $display("[TB] FAIL busy k=%0d: got %b expected %b", k, busy, (k < N));
      if (busy !== (k < N)) errors++;
      checks++;
      if (done !== (k == N)) begin
        $display("[TB] FAIL done k=%0d: got %b expected %b", k, done, (k == N));
        errors++;
      end
      checks++;
      if (s !== (exp[15:0] & keep)) begin
        $display("[TB] FAIL S k=%0d op %h%s%h: got %h expected %h", k, op_a,
                 op_sub ? "-" : "+", op_b, s, exp[15:0] & keep);
        errors++;
      end
      checks++;
      if (cout !== exp_c) begin
        $display("[TB] FAIL Cout k=%0d: got %b expected %b", k, cout, exp_c);
        errors++;
      end
      checks++;
      if (v !== exp_v) begin
        $display("[TB] FAIL V k=%0d: got %b expected %b", k, v, exp_v);
        errors++;
      end
    end
    prev_s = exp[15:0];
    prev_c = exp[16];
    prev_v = exp[17];
  endtask

  task automatic idle_after_done(input string name);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      $display("[TB] FAIL %s idle: got busy=%b done=%b expected 0 0", name, busy, done);
      errors++;
    end
    checks++;
    if (s !== prev_s || cout !== prev_c || v !== prev_v) begin
      $display("[TB] FAIL %s hold: got %h/%b/%b expected %h/%b/%b", name, s, cout, v,
               prev_s, prev_c, prev_v);
      errors++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    checks++;
    if ({busy, done, s, cout, v} !== 20'h0) begin
      $display("[TB] FAIL reset4: got %h expected 0", {busy, done, s, cout, v});
      errors++;
    end
    checks++;
    if ({busy1, done1, s1, cout1, v1} !== 8'h0) begin
      $display("[TB] FAIL reset1: got %h expected 0", {busy1, done1, s1, cout1, v1});
      errors++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_add();
    run_op4(16'h1234, 16'h4321, 1'b0, 1'b0);
    checks++;
    if ({s, cout, v} !== {16'h5555, 1'b0, 1'b0}) begin
      $display("[TB] FAIL basic_add: got %h/%b/%b expected 5555/0/0", s, cout, v);
      errors++;
    end
    idle_after_done("basic_add");
  endtask

  task automatic test_carry_and_overflow();
    run_op4(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    checks++;
    if ({s, cout, v} !== {16'h0000, 1'b1, 1'b0}) begin
      $display("[TB] FAIL carry_ripple: got %h/%b/%b expected 0000/1/0", s, cout, v);
      errors++;
    end
    idle_after_done("carry_ripple");
    run_op4(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    checks++;
    if ({s, cout, v} !== {16'h8000, 1'b0, 1'b1}) begin
      $display("[TB] FAIL add_ovf: got %h/%b/%b expected 8000/0/1", s, cout, v);
      errors++;
    end
    idle_after_done("add_ovf");
  endtask

  task automatic test_subtract();
    run_op4(16'h0005, 16'h0007, 1'b1, 1'b0);
    checks++;
    if ({s, cout, v} !== {16'hFFFE, 1'b0, 1'b0}) begin
      $display("[TB] FAIL sub_borrow: got %h/%b/%b expected FFFE/0/0", s, cout, v);
      errors++;
    end
    idle_after_done("sub_borrow");
    run_op4(16'h8000, 16'h0001, 1'b1, 1'b0);
    checks++;
    if ({s, cout, v} !== {16'h7FFF, 1'b1, 1'b1}) begin
      $display("[TB] FAIL sub_ovf: got %h/%b/%b expected 7FFF/1/1", s, cout, v);
      errors++;
    end
    idle_after_done("sub_ovf");
  endtask

  task automatic test_back_to_back();
    run_op4(16'h1111, 16'h2222, 1'b0, 1'b1);
    checks++;
    if (s !== 16'h3333) begin
      $display("[TB] FAIL hold_start: got %h expected 3333", s);
      errors++;
    end
    run_op4(16'h0001, 16'h0001, 1'b0, 1'b0);
    checks++;
    if (s !== 16'h0002) begin
      $display("[TB] FAIL back_to_back: got %h expected 0002", s);
      errors++;
    end
    idle_after_done("back_to_back");
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1;
    a     = 16'h0F0F;
    b     = 16'h0101;
    sub   = 1'b0;
    for (int k = 0; k <= 2; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, s, cout, v} !== 20'h0) begin
      $display("[TB] FAIL async_reset: got %h expected 0", {busy, done, s, cout, v});
      errors++;
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    prev_s = '0;
    prev_c = 1'b0;
    prev_v = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        $display("[TB] FAIL post_reset k=%0d: got busy=%b done=%b expected 0 0", k, busy, done);
        errors++;
      end
    end
    run_op4(16'h00FF, 16'h0001, 1'b0, 1'b0);
    checks++;
    if (s !== 16'h0100) begin
      $display("[TB] FAIL after_reset_op: got %h expected 0100", s);
      errors++;
    end
    idle_after_done("after_reset_op");
  endtask

  task automatic test_random_ops();
    for (int n = 0; n < 24; n++) begin
      run_op4(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) idle_after_done("random");
    end
    idle_after_done("random_end");
  endtask

  task automatic test_single_nibble();
    logic [17:0] exp;
    logic [3:0]  ra, rb;
    logic        rs;
    for (int n = 0; n < 10; n++) begin
      ra = (n == 0) ? 4'hF : 4'($urandom);
      rb = (n == 0) ? 4'h1 : 4'($urandom);
      rs = (n == 0) ? 1'b0 : 1'($urandom);
      exp = model(4, {12'h0, ra}, {12'h0, rb}, rs);
      start1 = 1'b1;
      a1     = ra;
      b1     = rb;
      sub1   = rs;
      for (int k = 0; k <= 1; k++) begin
        @(negedge clk);
        start1 = 1'b0;
        a1     = 4'($urandom);
        checks++;
        if (busy1 !== (k == 0) || done1 !== (k == 1)) begin
          $display("[TB] FAIL n1_handshake k=%0d: got busy=%b done=%b expected %b %b",
                   k, busy1, done1, (k == 0), (k == 1));
          errors++;
        end
      end
      checks++;
      if ({s1, cout1, v1} !== {exp[3:0], exp[16], exp[17]}) begin
        $display("[TB] FAIL n1_result %h%s%h: got %h/%b/%b expected %h/%b/%b", ra,
                 rs ? "-" : "+", rb, s1, cout1, v1, exp[3:0], exp[16], exp[17]);
        errors++;
      end
      if (n == 0) begin
        checks++;
        if ({s1, cout1, v1} !== {4'h0, 1'b1, 1'b0}) begin
          $display("[TB] FAIL n1_directed: got %h/%b/%b expected 0/1/0", s1, cout1, v1);
          errors++;
        end
      end
    end
    @(negedge clk);
    checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0) begin
      $display("[TB] FAIL n1_idle: got busy=%b done=%b expected 0 0", busy1, done1);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_carry_and_overflow();
    test_subtract();
    test_back_to_back();
    test_reset_mid_run();
    test_random_ops();
    test_single_nibble();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
